// File: rtl/load_store_unit.sv
// Load/store controller for the word-wide data memory: byte/half/word access with RMW sub-word stores.
// Optional alignment check enabled by defining LSU_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory word read at the captured address
// WR    | single-cycle memory write
// RESP  | one-cycle response pulse
module load_store_unit #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state, state_nx;
    logic              accept;
    logic              misaligned;
    logic              cap_we;
    logic              cap_unsigned;
    logic [1:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign accept   = req_valid && req_ready;
    assign mem_addr = {cap_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            default: misaligned = |req_addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)                state_nx = RESP;
                    else if (req_we && req_size[1]) state_nx = WR;
                    else                           state_nx = RD;
                end
            end
            RD:      state_nx = cap_we ? WR : RESP;
            WR:      state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Lane selection and extension act on the live read word; RMW merges into the word captured in RD.
    always_comb begin
        byte_sel = mem_rd_data[{cap_addr[1:0], 3'b000} +: 8];
        half_sel = cap_addr[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        if (cap_size[1])
            load_data = mem_rd_data;
        else if (cap_size[0])
            load_data = cap_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        else
            load_data = cap_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};

        merged = rd_word;
        if (cap_size[1])
            merged = cap_wdata;
        else if (cap_size[0])
            merged[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
        else
            merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
    end

    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = (state == RESP);
        mem_wr_en   = (state == WR);
        mem_wr_data = (state == WR) ? merged : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we       <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_size     <= 2'b00;
            cap_addr     <= '0;
            cap_wdata    <= 32'h0;
            rd_word      <= 32'h0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
        end else begin
            if (accept) begin
                cap_we       <= req_we;
                cap_unsigned <= req_unsigned;
                cap_size     <= req_size;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept && misaligned) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b1;
                    end
                end
                RD: begin
                    if (cap_we) begin
                        rd_word <= mem_rd_data;
                    end else begin
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end
                end
                WR: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses and writes,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_load_store_unit;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge.
    logic [31:0] mem [0:DEPTH/4-1];
    initial for (int i = 0; i < DEPTH/4; i++) mem[i] = 32'h0;
    assign mem_rd_data = mem[mem_addr[ADDR_W-1:2]];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr[ADDR_W-1:2]] <= mem_wr_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { string name; logic [31:0] rdata; logic err; int cyc; } resp_t;
    typedef struct { string name; logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];

    int checks = 0;
    int errors = 0;
    int last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                resp_t e;
                e = rq.pop_front();
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
                chk({e.name, "_resp_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_wr_en) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk({w.name, "_wr_addr"}, 32'(mem_addr), w.addr);
                chk({w.name, "_wr_data"}, mem_wr_data, w.data);
                chk({w.name, "_wr_cycle"}, 32'(cyc), 32'(w.cyc));
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input logic exp_wr, input logic [31:0] exp_wdata, input logic hold);
        int n;
        resp_t r;
        wr_t   w;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr[ADDR_W-1:0];
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({name, "_accept_timeout"}, 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (lat > 0) begin
            r.name = name; r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + lat;
            rq.push_back(r);
        end
        if (exp_wr) begin
            w.name = name;
            w.addr = 32'({addr[ADDR_W-1:2], 2'b00});
            w.data = exp_wdata;
            w.cyc  = cyc + lat - 1;
            wq.push_back(w);
        end
        @(posedge clk);
        #1;
        // Fields change after acceptance and must be ignored.
        req_valid    = hold;
        req_we       = ~we;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = ~addr[ADDR_W-1:0];
        req_wdata    = ~wdata;
    endtask

    initial begin
        int a1;
        int n;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //     name         we    size  uns   addr     wdata          rdata          err  lat wr    wdata exp      hold
        issue("sw_w0",      1'b1, 2'd2, 1'b0, 32'h000, 32'h11223344, 32'h0,        1'b0, 2, 1'b1, 32'h11223344, 1'b0);
        issue("sw_4",       1'b1, 2'd2, 1'b0, 32'h004, 32'hABCDABCD, 32'h0,        1'b0, 2, 1'b1, 32'hABCDABCD, 1'b0);
        issue("lw_4",       1'b0, 2'd2, 1'b0, 32'h004, 32'h0,        32'hABCDABCD, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("sb_5",       1'b1, 2'd0, 1'b0, 32'h005, 32'hFFFFFF5A, 32'h0,        1'b0, 3, 1'b1, 32'hABCD5ACD, 1'b0);
        issue("lb_5",       1'b0, 2'd0, 1'b0, 32'h005, 32'h0,        32'h0000005A, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("lb_7",       1'b0, 2'd0, 1'b0, 32'h007, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("lbu_7",      1'b0, 2'd0, 1'b1, 32'h007, 32'h0,        32'h000000AB, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("sw_14",      1'b1, 2'd3, 1'b0, 32'h014, 32'hABCDFFFF, 32'h0,        1'b0, 2, 1'b1, 32'hABCDFFFF, 1'b0);
        issue("sh_16",      1'b1, 2'd1, 1'b0, 32'h016, 32'hEEEE1234, 32'h0,        1'b0, 3, 1'b1, 32'h1234FFFF, 1'b0);
        issue("lh_14",      1'b0, 2'd1, 1'b0, 32'h014, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("lhu_16",     1'b0, 2'd1, 1'b1, 32'h016, 32'h0,        32'h00001234, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("lh_16",      1'b0, 2'd1, 1'b0, 32'h016, 32'h0,        32'h00001234, 1'b0, 2, 1'b0, 32'h0,        1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        issue("lw_2_mis",   1'b0, 2'd2, 1'b0, 32'h002, 32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0,        1'b0);
        issue("sh_3_mis",   1'b1, 2'd1, 1'b0, 32'h003, 32'h00009999, 32'h0,        1'b1, 1, 1'b0, 32'h0,        1'b0);
        issue("lw_0_after", 1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'h11223344, 1'b0, 2, 1'b0, 32'h0,        1'b0);
`else
        issue("lw_2_noal",  1'b0, 2'd2, 1'b0, 32'h002, 32'h0,        32'h11223344, 1'b0, 2, 1'b0, 32'h0,        1'b0);
        issue("sh_3_noal",  1'b1, 2'd1, 1'b0, 32'h003, 32'h00009999, 32'h0,        1'b0, 3, 1'b1, 32'h99993344, 1'b0);
        issue("lw_0_after", 1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'h99993344, 1'b0, 2, 1'b0, 32'h0,        1'b0);
`endif

        // Reset while SB @0x014 is in WR: no write, no response.
        issue("sb_14_rst",  1'b1, 2'd0, 1'b0, 32'h014, 32'h00000077, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid_wr_en_before", 32'(mem_wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en_after", 32'(mem_wr_en), 32'h0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'h1);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_ready_release", 32'(req_ready), 32'h1);
        chk("rst_mid_mem_word", mem[5], 32'h1234FFFF);
        issue("lw_14_rst",  1'b0, 2'd2, 1'b0, 32'h014, 32'h0,        32'h1234FFFF, 1'b0, 2, 1'b0, 32'h0,        1'b0);

        // Address wrap and back-to-back with req_valid held high.
        issue("sw_400",     1'b1, 2'd2, 1'b0, 32'h400, 32'hF0F0F0F0, 32'h0,        1'b0, 2, 1'b1, 32'hF0F0F0F0, 1'b1);
        a1 = last_acc;
        issue("lw_0_b2b",   1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hF0F0F0F0, 1'b0, 2, 1'b0, 32'h0,        1'b1);
        chk("b2b_gap", 32'(last_acc - a1), 32'h3);
        issue("lw_400",     1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'hF0F0F0F0, 1'b0, 2, 1'b0, 32'h0,        1'b0);

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("wrap_mem_word0", mem[0], 32'hF0F0F0F0);
        chk("resp_queue_empty", 32'(rq.size()), 32'h0);
        chk("write_queue_empty", 32'(wq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the byte-addressed, 32-bit-wide data memory (`ram_memory`) of the MIPS datapath. It accepts one load or store request at a time from the core. It performs byte, halfword and word accesses against the word-wide memory, using read-modify-write for sub-word stores. It returns sign- or zero-extended load data with a single-cycle response pulse.

## Interface
- `DEPTH`, 1024: memory size in bytes.
- `ADDR_W`, `$clog2(DEPTH)`: byte-address width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: request size.
  - 00 byte, 01 half, 10 word.
  - 11 treated as word.
- `req_unsigned` in 1: zero-extend loads; ignored for word and for stores.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores.
- `resp_err` out 1: misaligned request, valid with `resp_valid`.
- `mem_wr_en` out 1: memory write enable.
- `mem_addr` out ADDR_W: word-aligned byte address (bits [1:0] = 0).
- `mem_wr_data` out 32: memory write word.
- `mem_rd_data` in 32: memory read word; combinational from `mem_addr`.

## Operation
- Byte lanes: byte at address A+k (A word-aligned) is `mem_*_data[8k+7:8k]`.
- Halfword at offset 0 uses [15:0]; at offset 2 uses [31:16].
- Handshake:
  - `req_ready` = (state == IDLE).
  - Accept when `req_valid && req_ready` at a rising edge.
  - All `req_*` fields are captured into registers on acceptance; later changes are ignored.
- FSM states:
  - IDLE.
  - RD: drive `mem_addr`; sample `mem_rd_data` at the edge.
  - WR: `mem_wr_en`=1 for exactly one cycle.
  - RESP: `resp_valid`=1.
- Transitions:
  - Load: IDLE→RD→RESP→IDLE.
  - SW: IDLE→WR→RESP→IDLE; write word = `req_wdata`.
  - SB/SH: IDLE→RD→WR→RESP→IDLE.
    - WR word = captured read word with the addressed lane(s) replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
  - Misaligned (see Configuration): IDLE→RESP with `resp_err`=1; no memory access.
- Load extension:
  - Byte and half: sign-extend, or zero-extend when `req_unsigned`=1.
  - Word: passed through unchanged.
- Addresses are truncated to ADDR_W bits, so they wrap modulo DEPTH.
- `mem_addr` = captured address with bits [1:0] cleared; it holds the last value in IDLE.
- `mem_wr_en` is decoded combinationally from state and is never high outside WR.

## Timing
- Cycle 0 is the acceptance cycle.
- Response cycles:
  - Load: `resp_valid` in cycle 2.
  - SW: `resp_valid` in cycle 2.
  - SB/SH: `resp_valid` in cycle 3.
  - Misaligned: `resp_valid` in cycle 1.
- RESP always returns to IDLE, so the next acceptance is possible no earlier than the cycle after RESP.
- `req_valid` held high therefore yields one request per 3–4 cycles.
- `resp_valid` has no backpressure; it is high for exactly one cycle.
- `resp_rdata` and `resp_err` are registered; they hold until the next RESP.
- Reset values:
  - State = IDLE.
  - `resp_valid`, `resp_err`, `resp_rdata`, `mem_wr_en`, `mem_addr`, `mem_wr_data` = 0.
  - `req_ready` = 1.
- Reset mid-operation:
  - The FSM returns to IDLE immediately.
  - `mem_wr_en` drops before the next edge, so no write occurs.
  - The in-flight request is dropped and no response is issued.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Misaligned requests are flagged: half with `req_addr[0]`=1, or word with `req_addr[1:0]`≠0.
  - They return `resp_err`=1 and `resp_rdata`=0, with no memory access.
- Not defined:
  - No alignment check; `resp_err` is tied 0.
  - Half uses `req_addr[1]` only; word ignores `req_addr[1:0]`.

## Test plan
- Store then load word:
  - SW 0xABCDABCD @0x004 → `mem_wr_en` high only in cycle 1, with `mem_addr`=0x004; `resp_valid` in cycle 2.
  - LW @0x004 → `resp_rdata`=0xABCDABCD in cycle 2.
- Byte read-modify-write:
  - SB 0x5A @0x005 over 0xABCDABCD → memory word 0x004 = 0xABCD5ACD.
  - LB @0x005 → 0x0000005A.
  - LB @0x007 → 0xFFFFFFAB.
  - LBU @0x007 → 0x000000AB.
- Halfword:
  - SH 0x1234 @0x016 over 0xABCDFFFF at 0x014 → word = 0x1234FFFF.
  - LH @0x014 → 0xFFFFFFFF.
  - LHU @0x016 → 0x00001234.
- Misalignment, LW @0x002:
  - With the macro → `resp_err`=1 in cycle 1, no `mem_wr_en`.
  - Without the macro → returns word 0x000.
  - SH @0x003 with the macro → `resp_err`=1 and memory unchanged.
- Reset during WR of SB @0x014:
  - Expected: `mem_wr_en` falls immediately and no `resp_valid` is issued.
  - Expected: the word reads back unchanged after release, and `req_ready`=1.
- Wrap and back-to-back, with `req_valid` held high:
  - SW 0xF0F0F0F0 @0x400 (DEPTH=1024) writes word 0x000.
  - The next request is accepted the cycle after RESP.
